// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller.
package alu_ctrl_pkg;

  // Default datapath widths; these must match the ALU instance.
  localparam int ALU_W   = 64;
  localparam int ALU_OPW = 4;

  // Opcode constants; only ADD is defined, every other code is reserved.
  localparam logic [3:0] OP_ADD = 4'h0;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Bus bundle between requesters, the shared ALU and the response consumer.
// The controller uses the slave view; the surrounding system uses master.
interface alu_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int W    = 64,
  parameter int OPW  = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ*OPW-1:0] req_op;
  logic [W-1:0]        alu_a;
  logic [W-1:0]        alu_b;
  logic [OPW-1:0]      alu_op;
  logic [W-1:0]        alu_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [W-1:0]        rsp_result;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping to the lowest index when nothing is pending above ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);
  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] req_hi;
  logic            found;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
    assign hi_mask[gi]    = (IDW'(gi) >= ptr);
    assign gnt_onehot[gi] = any && (gnt_idx == IDW'(gi));
  end

  assign req_hi = req & hi_mask;
  assign any    = |req;

  // Lowest pending index at/above ptr, else lowest pending index overall
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_hi[k]) begin
        found   = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU among NREQ requesters. One operation is in
// flight at a time: accept (IDLE) -> ALU samples (EXEC) -> result
// captured (CAPT) -> response held until consumed (RESP).
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ALU_W,
  parameter int OPW  = ALU_OPW,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic          clk,
  input logic          rst_n,
  alu_share_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_CAPT = CAPT;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [W-1:0]   issue_a_q, issue_b_q;
  logic [OPW-1:0] issue_op_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_result_q;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            arb_any;
  logic            accept;

  // Per-requester views of the packed operand/opcode buses
  logic [W-1:0]   a_arr  [NREQ];
  logic [W-1:0]   b_arr  [NREQ];
  logic [OPW-1:0] op_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]  = bus.req_a[gi*W +: W];
    assign b_arr[gi]  = bus.req_b[gi*W +: W];
    assign op_arr[gi] = bus.req_op[gi*OPW +: OPW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (bus.req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (arb_any)
  );

  // Only IDLE accepts; gating with rst_n keeps req_ready low during reset
  // even though the arbiter sees pending requests.
  assign accept        = (state_q == ST_IDLE) && arb_any;
  assign bus.req_ready = (accept ? gnt_onehot : '0) & {NREQ{rst_n}};

  // Next state and next round-robin pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_EXEC;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_EXEC: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and arbitration pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Issue registers and response tag, loaded on accept; they hold the
  // last issued operation so the ALU inputs stay stable outside EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_a_q  <= '0;
      issue_b_q  <= '0;
      issue_op_q <= '0;
      rsp_id_q   <= '0;
    end else if (accept) begin
      issue_a_q  <= a_arr[gnt_idx];
      issue_b_q  <= b_arr[gnt_idx];
      issue_op_q <= op_arr[gnt_idx];
      rsp_id_q   <= gnt_idx;
    end
  end

  // Capture the ALU result in the cycle after the ALU sampled its inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
    end else if (state_q == ST_CAPT) begin
      rsp_result_q <= bus.alu_result;
    end
  end

  assign bus.alu_a      = issue_a_q;
  assign bus.alu_b      = issue_b_q;
  assign bus.alu_op     = issue_op_q;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Shares the single 64-bit registered ALU between `NREQ` requesters. Round-robin arbitration selects one pending operation, which is sequenced through the ALU's one-cycle registered path. The result is returned on a shared response channel tagged with the requester index. It sits between the requesting units (sequencers, address generators) and the ALU instance, and is the only driver of the ALU's `a`, `b` and `op` inputs.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 64: operand and result width; must match the ALU.
- `OPW`, default 4: opcode width; must match the ALU.
- `IDW`, default `$clog2(NREQ)`: requester-index width; derived, do not override.
- `clk`  in  1  single clock for the block and the ALU.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operation pending.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `req_a`  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- `req_b`  in  NREQ*W  operand B, packed the same way.
- `req_op`  in  NREQ*OPW  opcode, requester i at bits [i*OPW +: OPW].
- `alu_a`  out  W  to ALU `a`.
- `alu_b`  out  W  to ALU `b`.
- `alu_op`  out  OPW  to ALU `op`.
- `alu_result`  in  W  from ALU `result`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accepts.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  W  ALU result.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, CAPT, RESP.
- IDLE:
  - If any `req_valid` is high, the arbiter picks grant `g`: first set bit searching upward from `ptr`, modulo `NREQ`.
  - `req_ready[g]` is 1 combinationally in that cycle.
  - On the clock edge: `req_a/b/op` of `g` are latched into the issue registers, `rsp_id` <= `g`, `ptr` <= `(g+1) mod NREQ`, and the FSM moves to EXEC.
  - If no `req_valid` is high, the FSM stays in IDLE and `req_ready` is 0.
- EXEC: the issue registers drive `alu_a/b/op`; the ALU samples them at the end of this cycle. The FSM moves to CAPT.
- CAPT: `alu_result` is valid. `rsp_result` <= `alu_result`; the FSM moves to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_id` and `rsp_result` are held stable until `rsp_valid && rsp_ready`.
  - On that handshake the FSM moves to IDLE.
- `req_ready` is 0 in every state except IDLE. At most one bit is ever set.
- `alu_a/b/op` hold their last issued values outside EXEC. No other logic writes them.
- The block does not interpret the opcode; undefined opcodes pass through, and whatever the ALU returns is forwarded.
- Results are full `W` bits; overflow and carry are not reported.
- Requester `valid` may drop while not granted; no state is kept for non-granted requesters.
- Reset values: state = IDLE, `ptr` = 0, `req_ready` = 0 (also forced 0 while `rst_n` is low), `alu_a` = 0, `alu_b` = 0, `alu_op` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `busy` = 0.
- Reset mid-operation: the in-flight operation is discarded with no response. After release, the block starts in IDLE with `ptr` = 0.

## Timing
- Accept in cycle T, EXEC in T+1, CAPT in T+2, `rsp_valid` high from T+3.
- Minimum issue interval is 4 cycles when `rsp_ready` is held high: a new accept can occur in T+4.
- `rsp_ready` low stalls in RESP indefinitely; no new requests are accepted during the stall.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes in the first cycle of RESP.
- `busy` falls in the cycle after the response handshake.

## Structure
- Package `alu_ctrl_pkg` holds the state enum (`IDLE`, `EXEC`, `CAPT`, `RESP`), the default `W`/`OPW`, and opcode constants (`OP_ADD = 4'h0`, other codes reserved).
- Sub-module `rr_arbiter` (params `NREQ`):
  - inputs `req[NREQ]`, `ptr[IDW]`
  - outputs `gnt_onehot[NREQ]`, `gnt_idx[IDW]`, `any`
  - purely combinational
- `ptr` and the FSM live in `alu_share_ctrl`.

## Test plan
- Single request: requester 2 issues op 0, a=5, b=7, `rsp_ready`=1. Expect `req_ready[2]` high in T, `rsp_valid` in T+3 with `rsp_id`=2 and `rsp_result`=12.
- All four requesters valid continuously from reset, op 0, a=i, b=100. Expect grants in order 0,1,2,3,0 at 4-cycle spacing, with results 100,101,102,103.
- Wrap-around add: a=64'hFFFF_FFFF_FFFF_FFFF, b=1. Expect `rsp_result`=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after `rsp_valid` rises. Expect `rsp_id`/`rsp_result` stable, `req_ready` all 0, `busy`=1; completion in the cycle `rsp_ready` rises.
- Reserved op 4'h5 with a=3, b=4. Expect `rsp_result`=0.
- Assert `rst_n` low during CAPT. Expect immediate `rsp_valid`=0 and `busy`=0 with no response for that request. After release, a pending requester 1 is granted first only if requester 0 is idle (`ptr`=0).
